// File: rtl/mul_acc_iter_pkg.sv
// Shared definitions for the iterative multiply / multiply-accumulate unit.
// Handshake constants mirror the divider so the execute stage treats both alike.
package mul_acc_iter_pkg;

    typedef enum logic [1:0] {
        MulIdle = 2'b00,
        MulCalc = 2'b01,
        MulFix  = 2'b10,
        MulDone = 2'b11
    } mul_state_e;

    typedef enum logic [1:0] {
        MulModeMul  = 2'b00,
        MulModeMadd = 2'b01,
        MulModeMsub = 2'b10
    } mul_mode_e;

    localparam logic MulStart          = 1'b1;
    localparam logic MulStop           = 1'b0;
    localparam logic MulResultReady    = 1'b1;
    localparam logic MulResultNotReady = 1'b0;

    function automatic bit radix_legal(input int width, input int radix);
        return ((radix == 1) || (radix == 2) || (radix == 4) || (radix == 8)) &&
               ((width % radix) == 0);
    endfunction

endpackage

// File: rtl/mul_acc_iter_if.sv
// Execute-stage <-> multiplier handshake bus; master is the execute stage.
interface mul_acc_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic                 signed_i;
    logic [1:0]           mode_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   acc_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output start_i, annul_i, signed_i, mode_i, opdata1_i, opdata2_i, acc_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, mode_i, opdata1_i, opdata2_i, acc_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/mul_pp_step.sv
// Combinational partial product: mcand times a RADIX_BITS multiplier slice,
// positioned at the current digit's weight within the double-width product.
module mul_pp_step #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2,
    parameter int SH_W       = 6
) (
    input  logic [WIDTH-1:0]      mcand_i,
    input  logic [RADIX_BITS-1:0] slice_i,
    input  logic [SH_W-1:0]       shamt_i,
    output logic [2*WIDTH-1:0]    addend_o
);
    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp       = {{WIDTH{1'b0}}, mcand_i} * {{(2*WIDTH-RADIX_BITS){1'b0}}, slice_i};
        addend_o = pp << shamt_i;
    end
endmodule

// File: rtl/mul_acc_iter.sv
// Iterative MULT/MADD/MSUB unit: magnitudes are multiplied RADIX_BITS per cycle,
// then sign, msub negation and accumulate are applied in a single FIX cycle.
module mul_acc_iter
    import mul_acc_iter_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    mul_acc_iter_if.slave bus
);
    localparam int STEPS = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int SH_W  = $clog2(2 * WIDTH);

    if (!radix_legal(WIDTH, RADIX_BITS)) begin : g_bad_radix
        $error("mul_acc_iter: RADIX_BITS must be 1, 2, 4 or 8 and divide WIDTH");
    end

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
    logic [2*WIDTH-1:0] product_q, product_d, acc_q, acc_d, result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               neg_q, neg_d, ready_q, ready_d, busy_q, busy_d;
    logic [2*WIDTH-1:0] addend, fix_p;
    logic [SH_W-1:0]    shamt;

    assign shamt = SH_W'(int'(cnt_q) * RADIX_BITS);

    mul_pp_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS),
        .SH_W       (SH_W)
    ) u_pp_step (
        .mcand_i  (mcand_q),
        .slice_i  (mplier_q[RADIX_BITS-1:0]),
        .shamt_i  (shamt),
        .addend_o (addend)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        neg_d     = neg_q;
        result_d  = result_q;
        ready_d   = ready_q;
        fix_p     = '0;

        if (bus.annul_i) begin
            state_d  = MulIdle;
            result_d = '0;
            ready_d  = MulResultNotReady;
        end else begin
            case (state_q)
                MulIdle: begin
                    if (bus.start_i == MulStart) begin
                        mode_d    = bus.mode_i;
                        acc_d     = bus.acc_i;
                        neg_d     = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        // Most-negative input negates to itself, which is its correct unsigned magnitude.
                        mcand_d   = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
                        mplier_d  = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
                        product_d = '0;
                        cnt_d     = '0;
                        state_d   = ((bus.opdata1_i == '0) || (bus.opdata2_i == '0)) ? MulFix : MulCalc;
                    end
                end
                MulCalc: begin
                    product_d = product_q + addend;
                    mplier_d  = mplier_q >> RADIX_BITS;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        state_d = MulFix;
                    end
                end
                MulFix: begin
                    fix_p = neg_q ? -product_q : product_q;
                    if (mode_q == MulModeMsub) begin
                        fix_p = -fix_p;
                    end
                    result_d = ((mode_q == MulModeMadd) || (mode_q == MulModeMsub)) ? fix_p + acc_q : fix_p;
                    ready_d  = MulResultReady;
                    state_d  = MulDone;
                end
                MulDone: begin
                    if (bus.start_i == MulStop) begin
                        state_d  = MulIdle;
                        result_d = '0;
                        ready_d  = MulResultNotReady;
                    end
                end
                default: state_d = MulIdle;
            endcase
        end

        busy_d = (state_d != MulIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MulIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
            neg_q     <= 1'b0;
            result_q  <= '0;
            ready_q   <= MulResultNotReady;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            neg_q     <= neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = busy_q;
endmodule

// File: tb/tb_mul_acc_iter.sv
// Drives three radix variants (2, 1, 4) with identical stimulus; a per-instance
// scoreboard holds expected results and the cycle at which ready must rise.
module tb_mul_acc_iter;
    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] res;
        int unsigned    due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, annul, sgn;
    logic [1:0]     mode;
    logic [W-1:0]   op1, op2;
    logic [2*W-1:0] acc;

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t           exp_q [3][$];
    logic [2:0]     ready_v, busy_v;
    logic [2*W-1:0] res_v [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int radix_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 4;
    endfunction

    function automatic logic [2*W-1:0] model(input logic s, input logic [1:0] m,
                                             input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2*W-1:0] ac);
        longint x, y;
        logic [2*W-1:0] p;
        x = s ? longint'(signed'(a)) : longint'({32'b0, a});
        y = s ? longint'(signed'(b)) : longint'({32'b0, b});
        p = 64'(x * y);
        case (m)
            2'b01:   return ac + p;
            2'b10:   return ac - p;
            default: return p;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int R = (g == 0) ? 2 : (g == 1) ? 1 : 4;

        mul_acc_iter_if #(.WIDTH(W)) bus ();
        logic rdy_prev = 1'b0;
        exp_t e;

        assign bus.start_i   = start;
        assign bus.annul_i   = annul;
        assign bus.signed_i  = sgn;
        assign bus.mode_i    = mode;
        assign bus.opdata1_i = op1;
        assign bus.opdata2_i = op2;
        assign bus.acc_i     = acc;
        assign ready_v[g]    = bus.ready_o;
        assign busy_v[g]     = bus.busy_o;
        assign res_v[g]      = bus.result_o;

        mul_acc_iter #(.WIDTH(W), .RADIX_BITS(R)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        always @(negedge clk) begin
            if (bus.ready_o && !rdy_prev) begin
                if (exp_q[g].size() == 0) begin
                    check_eq($sformatf("r%0d_unexpected_ready", R), 64'(1), 64'(0));
                end else begin
                    e = exp_q[g].pop_front();
                    check_eq($sformatf("r%0d_result", R), bus.result_o, e.res);
                    check_eq($sformatf("r%0d_latency", R), 64'(cyc), 64'(e.due));
                end
            end
            rdy_prev <= bus.ready_o;
        end
    end

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 64'(ready_v), 64'(0));
        check_eq({tag, "_busy"}, 64'(busy_v), 64'(0));
        for (int g = 0; g < 3; g++) check_eq($sformatf("%s_res%0d", tag, g), res_v[g], '0);
    endtask

    task automatic run_op(input string name, input logic s, input logic [1:0] m,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] ac, input int unsigned hold);
        logic [2*W-1:0] expv;
        bit             zero;
        int unsigned    waited;
        expv = model(s, m, a, b, ac);
        zero = (a == '0) || (b == '0);
        @(negedge clk);
        sgn = s; mode = m; op1 = a; op2 = b; acc = ac; start = 1'b1;
        for (int g = 0; g < 3; g++) begin
            exp_t e;
            e.res = expv;
            e.due = zero ? cyc + 2 : cyc + 32 / radix_of(g) + 2;
            exp_q[g].push_back(e);
        end
        @(negedge clk);
        check_eq({name, "_busy"}, 64'(busy_v), 64'h7);
        // Inputs wiggle after acceptance; the unit must ignore them.
        op1 = ~a; op2 = a ^ b; acc = ~ac; mode = ~m; sgn = ~s;
        waited = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && waited < 80) begin
            @(negedge clk);
            waited++;
        end
        check_eq({name, "_timeout"}, 64'(waited < 80), 64'(1));
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({name, "_hold_ready"}, 64'(ready_v), 64'h7);
            for (int g = 0; g < 3; g++) check_eq({name, "_hold_res"}, res_v[g], expv);
        end
        start = 1'b0;
        @(negedge clk);
        check_idle({name, "_exit"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned c0;
        rst = 1'b1; start = 1'b0; annul = 1'b0; sgn = 1'b0; mode = 2'b00;
        op1 = '0; op2 = '0; acc = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        run_op("mul_s",    1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5,         64'd0, 0);
        run_op("mul_u",    1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 0);
        run_op("madd_s",   1'b1, 2'b01, 32'd7,         32'd6,         64'h10, 0);
        run_op("msub_min", 1'b1, 2'b10, 32'h8000_0000, 32'h8000_0000, 64'd0, 0);
        run_op("mode_rsv", 1'b1, 2'b11, 32'hFFFF_FFFE, 32'd3,         64'h1234_5678_9ABC_DEF0, 0);
        run_op("min_x1",   1'b1, 2'b00, 32'h8000_0000, 32'd1,         64'd0, 0);
        run_op("msub_u",   1'b0, 2'b10, 32'h0001_0000, 32'h0003_0000, 64'h5_0000_0000, 1);
        run_op("zero_madd",1'b1, 2'b01, 32'd0,         32'h1234,      64'h0000_0001_0000_1234, 3);
        run_op("zero_msub",1'b0, 2'b10, 32'hDEAD_BEEF, 32'd0,         64'h7, 0);

        // Annul mid-CALC: no result may appear on any instance.
        @(negedge clk);
        sgn = 1'b0; mode = 2'b00; op1 = 32'h10; op2 = 32'h10; acc = '0; start = 1'b1;
        repeat (5) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        check_idle("annul");
        annul = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("annul_quiet", 64'(ready_v), 64'(0));
        run_op("after_annul", 1'b0, 2'b00, 32'd3, 32'd3, 64'd0, 0);

        // Annul together with a start request in IDLE.
        @(negedge clk);
        op1 = 32'd2; op2 = 32'd2; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        check_eq("annul_idle_busy", 64'(busy_v), 64'(0));
        start = 1'b0; annul = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("annul_idle_ready", 64'(ready_v), 64'(0));

        // Reset mid-operation, then rerun the signed multiply.
        @(negedge clk);
        sgn = 1'b1; mode = 2'b00; op1 = 32'hFFFF_FFFD; op2 = 32'd5; start = 1'b1;
        c0 = cyc;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        check_eq("rst_mid_cycle", 64'(cyc - c0), 64'(8));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        run_op("mul_s_again", 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd5, 64'd0, 0);

        repeat (2) @(negedge clk);
        check_eq("sb_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mul_acc_iter.md
Name: mul_acc_iter

Overview:
- Parametrised iterative multiply / multiply-accumulate unit for the execute stage.
- Executes MULT/MULTU, MADD/MADDU and MSUB/MSUBU over WIDTH/RADIX_BITS cycles; replaces the single-cycle multiplier and two-cycle MADD/MSUB sequencing.
- Uses the same start/ready/annul handshake as the divider, so the execute stage holds start_i and stalls until ready_o.

Parameters:
- WIDTH, 32: operand width; result is 2*WIDTH.
- RADIX_BITS, 2: multiplier bits retired per cycle. Legal values 1, 2, 4, 8, and it must divide WIDTH; checked at elaboration.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request; held high by execute stage until it has consumed the result.
- annul_i  in  1  flush; abandons any operation.
- signed_i  in  1  1 = signed operands (MULT/MADD/MSUB), 0 = unsigned.
- mode_i  in  2  00 = mul, 01 = madd, 10 = msub, 11 = reserved (treated as mul).
- opdata1_i  in  WIDTH  multiplicand.
- opdata2_i  in  WIDTH  multiplier.
- acc_i  in  2*WIDTH  {HI,LO} after forwarding; used for madd/msub.
- result_o  out  2*WIDTH  final {HI,LO} value.
- ready_o  out  1  result valid.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset and annul give: result_o = 0, ready_o = 0, busy_o = 0, state = IDLE.
- States: IDLE, CALC, FIX, DONE. Priority order each cycle: rst, then annul_i, then normal operation.

IDLE:
- Transition condition: start_i = 1 and annul_i = 0.
- On that cycle, latch mode, signed flag and acc_i. acc_i is sampled only here; later changes are ignored.
- Latch operand magnitudes: two's-complement negate when signed_i = 1 and the MSB is 1. The magnitude of the most negative value (e.g. 0x80000000) is held as an unsigned WIDTH-bit value.
- Latch neg = signed_i & (op1 MSB ^ op2 MSB). Clear the product register and set cnt = 0.
- If either operand is zero, go to FIX (zero shortcut). Otherwise go to CALC.

CALC:
- Each cycle: product += mcand * mplier[RADIX_BITS-1:0], shifted left by cnt*RADIX_BITS. Then mplier >>= RADIX_BITS and cnt++.
- After WIDTH/RADIX_BITS cycles, go to FIX.
- Width rule: the product register is 2*WIDTH bits; no overflow is possible.

FIX (1 cycle):
- p = neg ? -product : product.
- If mode = msub, p = -p.
- result = p + acc for madd/msub; result = p for mul. The sum is modulo 2^(2*WIDTH), with no overflow flag.
- Register result_o and set ready_o = 1. Go to DONE.

DONE:
- Hold result_o and ready_o while start_i = 1.
- When start_i = 0: next cycle result_o = 0, ready_o = 0, state = IDLE.
- A new operation therefore needs one IDLE cycle with start_i = 0 first; start_i held continuously is not a new request.

Latency:
- Start accepted in cycle N (IDLE): ready_o = 1 in cycle N + WIDTH/RADIX_BITS + 2. For 32/2 this is N+18.
- Zero shortcut: ready_o = 1 in cycle N+2.

Boundary conditions:
- annul_i in CALC, FIX or DONE: IDLE next cycle, outputs zeroed, no result.
- annul_i together with start_i in IDLE: request ignored.
- start_i dropped mid-CALC: operation continues. If start_i is still low when DONE is reached, the block exits DONE one cycle later. The execute stage must not do this; the bench flags it as a protocol warning only.
- Operand changes after acceptance: ignored.

Decomposition:
- Shared defines package holds:
  - state encodings MulIdle, MulCalc, MulFix, MulDone;
  - mode encodings MulModeMul (2'b00), MulModeMadd (2'b01), MulModeMsub (2'b10);
  - handshake constants MulStart/MulStop and MulResultReady/MulResultNotReady, mirroring the divider constants.
- One sub-module is natural: mul_pp_step, a combinational partial-product generator. Inputs are mcand, the RADIX_BITS multiplier slice and the shift amount; output is a 2*WIDTH addend.
- FSM, counter, sign fix and accumulate stay in mul_acc_iter.

Test Plan:
1. Signed mul: signed_i = 1, mode 00, op1 = 0xFFFFFFFD (-3), op2 = 5 -> ready_o at N+18, result_o = 0xFFFFFFFF_FFFFFFF1; busy_o high N+1..N+18.
2. Unsigned mul: signed_i = 0, op1 = op2 = 0xFFFFFFFF -> result_o = 0xFFFFFFFE_00000001 at N+18.
3. madd and msub:
   - madd signed: acc_i = 0x00000000_00000010, 7*6 -> result_o = 0x00000000_0000003A.
   - msub signed: acc_i = 0, op1 = op2 = 0x80000000 -> result_o = 0xC0000000_00000000.
4. Zero shortcut: madd, op1 = 0, op2 = 0x1234, acc_i = 0x00000001_00001234 -> ready_o at N+2, result_o = acc_i. Then hold start_i 3 more cycles -> result held; drop start_i -> next cycle ready_o = 0, result_o = 0.
5. Annul: start mul 0x10*0x10, assert annul_i at N+5 -> state IDLE at N+6, ready_o never asserts. Restart with 3*3 -> 9 after full latency.
6. Reset mid-operation, then repeat with RADIX_BITS = 1 and 4:
   - rst at N+7 -> all outputs 0 next cycle;
   - rerun test 1 -> ready_o at N+34 (R = 1) and N+10 (R = 4), identical results.
